// File: rtl/vecmac_pkg.sv
// Shared constants, state encoding and helpers for the vector-MAC result path.
package vecmac_pkg;

    localparam int MAX_LEN    = 16;
    localparam int LEN_W      = $clog2(MAX_LEN) + 1;
    localparam int PROD_W     = 16;
    localparam int ACC_W      = PROD_W + $clog2(MAX_LEN);
    localparam int OBUF_DEPTH = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // A length of zero, or anything beyond MAX_LEN, means "full-length vector".
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        if (len == '0 || len > LEN_W'(MAX_LEN)) begin
            return LEN_W'(MAX_LEN);
        end
        return len;
    endfunction

endpackage

// File: rtl/vecmac_accum_if.sv
// Product stream in, dot-product result stream out.
interface vecmac_accum_if;
    import vecmac_pkg::*;

    logic              in_valid;
    logic [PROD_W-1:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;

    modport master (
        output in_valid, in_product, out_ready,
        input  out_valid, out_sum
    );

    modport slave (
        input  in_valid, in_product, out_ready,
        output out_valid, out_sum
    );

endinterface

// File: rtl/vecmac_sync_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and empty
// are distinguishable without a separate counter.
module vecmac_sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage and pointers; a full FIFO still accepts a push when it pops too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vecmac_accum.sv
// Accumulates N consecutive multiplier products into one dot-product result
// and queues completed sums for the downstream valid/ready consumer.
module vecmac_accum
    import vecmac_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             flush,
    input  logic             err_clr,
    output logic             busy,
    output logic             drop_err,
    vecmac_accum_if.slave    bus
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] eff_len;
    logic [ACC_W-1:0] prod_ext;
    logic             push;
    logic [ACC_W-1:0] push_data;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    assign eff_len       = clamp_len(cfg_len);
    assign prod_ext      = ACC_W'(bus.in_product);
    assign bus.out_valid = !fifo_empty;
    assign pop           = bus.out_valid && bus.out_ready;
    assign drop          = push && fifo_full && !pop;
    assign busy          = (state_q == ACCUM);

    // FSM and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic: the length is latched on the first beat, and a flush
    // discards any beat that shares its cycle.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && !flush) begin
                    if (eff_len == LEN_W'(1)) begin
                        push      = 1'b1;
                        push_data = prod_ext;
                    end else begin
                        acc_d   = prod_ext;
                        cnt_d   = LEN_W'(1);
                        len_d   = eff_len;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                if (flush) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.in_valid) begin
                    if (cnt_q + LEN_W'(1) == len_q) begin
                        push      = 1'b1;
                        push_data = acc_q + prod_ext;
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_q + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sticky drop flag; a new drop wins over a coincident clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_err <= 1'b0;
        end else if (drop) begin
            drop_err <= 1'b1;
        end else if (err_clr) begin
            drop_err <= 1'b0;
        end
    end

    vecmac_sync_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (bus.out_sum),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_vecmac_accum.sv
// Directed cycle-by-cycle vectors plus reset and random scoreboard sequences
// for the dot-product accumulator.
module tb_vecmac_accum;
    import vecmac_pkg::*;

    typedef struct {
        string       name;
        logic [4:0]  cfg_len;
        logic        valid;
        logic [15:0] product;
        logic        flush;
        logic        ready;
        logic        clr;
        logic        exp_ov;
        logic [19:0] exp_sum;
        logic        exp_busy;
        logic        exp_drop;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [4:0] cfg_len;
    logic       flush;
    logic       err_clr;
    logic       busy;
    logic       drop_err;
    int         errors;
    int         checks;
    vec_t       tbl[$];

    vecmac_accum_if bus ();

    vecmac_accum dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_len  (cfg_len),
        .flush    (flush),
        .err_clr  (err_clr),
        .busy     (busy),
        .drop_err (drop_err),
        .bus      (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(string name, logic [4:0] cl, logic v, logic [15:0] p,
                                   logic fl, logic rdy, logic clr, logic eov,
                                   logic [19:0] esum, logic ebusy, logic edrop);
        vec_t r;
        r.name = name; r.cfg_len = cl; r.valid = v; r.product = p; r.flush = fl;
        r.ready = rdy; r.clr = clr; r.exp_ov = eov; r.exp_sum = esum;
        r.exp_busy = ebusy; r.exp_drop = edrop;
        tbl.push_back(r);
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs and return #1 after the edge that samples them.
    task automatic applyStimulus(logic [4:0] cl, logic v, logic [15:0] p, logic fl,
                                 logic rdy, logic clr);
        cfg_len        = cl;
        bus.in_valid   = v;
        bus.in_product = p;
        flush          = fl;
        bus.out_ready  = rdy;
        err_clr        = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic int clampModel(int len);
        return (len == 0 || len > 16) ? 16 : len;
    endfunction

    initial begin
        errors         = 0;
        checks         = 0;
        rst            = 1'b1;
        cfg_len        = '0;
        flush          = 1'b0;
        err_clr        = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_product = '0;
        bus.out_ready  = 1'b0;

        // Basic: four full-scale beats.
        for (int i = 0; i < 3; i++) addVec("basic_beat", 5'd4, 1, 16'd65025, 0, 1, 0, 0, 0, 1, 0);
        addVec("basic_last", 5'd4, 1, 16'd65025, 0, 1, 0, 1, 20'd260100, 0, 0);
        addVec("basic_pop", 5'd4, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Worst case with cfg_len=0 clamped to 16, then single-beat vectors.
        for (int i = 0; i < 15; i++) addVec("worst_beat", 5'd0, 1, 16'd65025, 0, 1, 0, 0, 0, 1, 0);
        addVec("worst_last", 5'd0, 1, 16'd65025, 0, 1, 0, 1, 20'd1040400, 0, 0);
        addVec("len1_a", 5'd1, 1, 16'd7, 0, 1, 0, 1, 20'd7, 0, 0);
        addVec("len1_b", 5'd1, 1, 16'd9, 0, 1, 0, 1, 20'd9, 0, 0);
        addVec("len1_pop", 5'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Gaps, with cfg_len changed mid-vector (must not take effect).
        addVec("gap_b10", 5'd3, 1, 16'd10, 0, 1, 0, 0, 0, 1, 0);
        addVec("gap_idle1", 5'd5, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        addVec("gap_idle2", 5'd5, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        addVec("gap_b20", 5'd5, 1, 16'd20, 0, 1, 0, 0, 0, 1, 0);
        addVec("gap_b30", 5'd5, 1, 16'd30, 0, 1, 0, 1, 20'd60, 0, 0);
        addVec("gap_pop", 5'd3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Flush coinciding with the completing beat discards it.
        addVec("fl_b5", 5'd3, 1, 16'd5, 0, 1, 0, 0, 0, 1, 0);
        addVec("fl_b6", 5'd3, 1, 16'd6, 0, 1, 0, 0, 0, 1, 0);
        addVec("fl_b100", 5'd3, 1, 16'd100, 1, 1, 0, 0, 0, 0, 0);
        addVec("fl_idle", 5'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        addVec("fl_b1", 5'd3, 1, 16'd1, 0, 1, 0, 0, 0, 1, 0);
        addVec("fl_b2", 5'd3, 1, 16'd2, 0, 1, 0, 0, 0, 1, 0);
        addVec("fl_b3", 5'd3, 1, 16'd3, 0, 1, 0, 1, 20'd6, 0, 0);
        addVec("fl_pop", 5'd3, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // Backpressure and drop.
        addVec("bp_b1", 5'd1, 1, 16'd1, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("bp_b2", 5'd1, 1, 16'd2, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("bp_b3", 5'd1, 1, 16'd3, 0, 0, 0, 1, 20'd1, 0, 1);
        addVec("bp_hold", 5'd1, 0, 0, 0, 0, 0, 1, 20'd1, 0, 1);
        addVec("bp_pop1", 5'd1, 0, 0, 0, 1, 0, 1, 20'd2, 0, 1);
        addVec("bp_pop2", 5'd1, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        addVec("bp_clr", 5'd1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        // Push and pop together while full.
        addVec("pp_b1", 5'd1, 1, 16'd1, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("pp_b2", 5'd1, 1, 16'd2, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("pp_b3", 5'd1, 1, 16'd3, 0, 1, 0, 1, 20'd2, 0, 0);
        addVec("pp_pop2", 5'd1, 0, 0, 0, 1, 0, 1, 20'd3, 0, 0);
        addVec("pp_pop3", 5'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // err_clr coinciding with a drop leaves the flag set.
        addVec("ec_b1", 5'd1, 1, 16'd1, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("ec_b2", 5'd1, 1, 16'd2, 0, 0, 0, 1, 20'd1, 0, 0);
        addVec("ec_b3", 5'd1, 1, 16'd3, 0, 0, 1, 1, 20'd1, 0, 1);
        addVec("ec_clr", 5'd1, 0, 0, 0, 1, 1, 1, 20'd2, 0, 0);
        addVec("ec_pop", 5'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset values.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        checkOutput("rst_out_sum", 32'(bus.out_sum), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_drop_err", 32'(drop_err), 0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].cfg_len, tbl[i].valid, tbl[i].product, tbl[i].flush,
                          tbl[i].ready, tbl[i].clr);
            checkOutput($sformatf("%s[%0d].out_valid", tbl[i].name, i), 32'(bus.out_valid), 32'(tbl[i].exp_ov));
            checkOutput($sformatf("%s[%0d].busy", tbl[i].name, i), 32'(busy), 32'(tbl[i].exp_busy));
            checkOutput($sformatf("%s[%0d].drop_err", tbl[i].name, i), 32'(drop_err), 32'(tbl[i].exp_drop));
            if (tbl[i].exp_ov)
                checkOutput($sformatf("%s[%0d].out_sum", tbl[i].name, i), 32'(bus.out_sum), 32'(tbl[i].exp_sum));
        end

        // Asynchronous reset mid-vector with a result pending.
        applyStimulus(5'd1, 1, 16'd5, 0, 0, 0);
        checkOutput("mr_pending", 32'(bus.out_valid), 1);
        applyStimulus(5'd4, 1, 16'd1, 0, 0, 0);
        applyStimulus(5'd4, 1, 16'd1, 0, 0, 0);
        checkOutput("mr_busy_before", 32'(busy), 1);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mr_out_valid", 32'(bus.out_valid), 0);
        checkOutput("mr_busy", 32'(busy), 0);
        checkOutput("mr_out_sum", 32'(bus.out_sum), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(5'd4, 1, 16'd1, 0, 1, 0);
        checkOutput("mr_fresh_valid", 32'(bus.out_valid), 1);
        checkOutput("mr_fresh_sum", 32'(bus.out_sum), 4);
        applyStimulus(5'd4, 0, 0, 0, 1, 0);
        checkOutput("mr_fresh_pop", 32'(bus.out_valid), 0);

        // Random reference against a scoreboard; out_ready is never low for
        // two cycles in a row and vectors are at least two beats long.
        begin
            int   beats;
            int   m_len, m_cnt, m_acc;
            bit   m_busy, m_drop, prev_rdy, v, rdy, do_pop, do_push;
            int   push_val, r;
            logic [15:0] p;
            int   q[$];
            beats = 0; m_len = 0; m_cnt = 0; m_acc = 0;
            m_busy = 0; m_drop = 0; prev_rdy = 1;
            for (int cyc = 0; cyc < 20000 && beats < 1000; cyc++) begin
                v   = ($urandom_range(0, 9) < 7);
                p   = 16'($urandom_range(0, 65535));
                rdy = prev_rdy ? bit'($urandom_range(0, 1)) : 1'b1;
                r   = $urandom_range(0, 20);
                if (r == 1) r = 0;
                prev_rdy = rdy;
                do_pop   = (q.size() > 0) && rdy;
                do_push  = 0;
                push_val = 0;
                if (v) begin
                    beats++;
                    if (!m_busy) begin
                        m_len = clampModel(r); m_acc = int'(p); m_cnt = 1; m_busy = 1;
                    end else begin
                        m_acc += int'(p); m_cnt++;
                        if (m_cnt == m_len) begin
                            do_push = 1; push_val = m_acc; m_busy = 0; m_acc = 0; m_cnt = 0;
                        end
                    end
                end
                if (do_push && q.size() == 2 && !do_pop) m_drop = 1;
                if (do_pop) void'(q.pop_front());
                if (do_push && !(q.size() == 2)) q.push_back(push_val);
                applyStimulus(5'(r), v, p, 0, rdy, 0);
                checkOutput($sformatf("rnd%0d.out_valid", cyc), 32'(bus.out_valid), 32'(q.size() > 0));
                checkOutput($sformatf("rnd%0d.busy", cyc), 32'(busy), 32'(m_busy));
                if (q.size() > 0)
                    checkOutput($sformatf("rnd%0d.out_sum", cyc), 32'(bus.out_sum), 32'(q[0]));
            end
            checkOutput("rnd_beats_done", 32'(beats), 1000);
            checkOutput("rnd_drop_model", 32'(m_drop), 0);
            checkOutput("rnd_drop_err", 32'(drop_err), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vecmac_accum.md
Name: vecmac_accum

Overview:
- Sink end of the multiplier product stream: consumes the valid-only (in_valid, 16-bit unsigned product) output of wallace_mult8 and accumulates N consecutive products into one dot-product result.
- Completed sums enter a small output FIFO and drain through a valid/ready handshake toward the vector-MAC result path.
- Sits directly downstream of the multiplier lane(s) in int8_vecmac.

Parameters:
- MAX_LEN, 16: maximum vector length (products per result); power of two.
- LEN_W, 5: width of cfg_len, clog2(MAX_LEN)+1.
- ACC_W, 20: accumulator/result width, 16+clog2(MAX_LEN); worst case MAX_LEN*65025 = 1040400 must fit.
- OBUF_DEPTH, 2: output FIFO entries, power of two, at least 2.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- rst, in, 1: asynchronous, active-high reset.
- cfg_len, in, LEN_W: vector length, sampled on the first beat of each vector.
- in_valid, in, 1: product beat present; no backpressure, every valid beat is consumed.
- in_product, in, 16: unsigned product.
- flush, in, 1: abort the partial vector.
- out_valid, out, 1: head of the output FIFO is valid.
- out_ready, in, 1: downstream accepts the head.
- out_sum, out, ACC_W: result at the FIFO head.
- busy, out, 1: a vector is partially accumulated (state ACCUM).
- drop_err, out, 1: sticky flag; a completed result was discarded.
- err_clr, in, 1: clears drop_err.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_sum=0, busy=0, drop_err=0, FIFO empty, beat count=0, acc=0, state IDLE. Reset asserted mid-vector or mid-drain discards everything.
- Length: eff_len = cfg_len, except cfg_len=0 or cfg_len>MAX_LEN clamps to MAX_LEN. Latched on the first beat only; later changes to cfg_len do not affect the vector in progress.
- FSM IDLE:
  - in_valid with eff_len=1: complete immediately (sum=in_product), stay in IDLE.
  - in_valid otherwise: acc=in_product, cnt=1, go to ACCUM.
- FSM ACCUM:
  - each in_valid adds in_product to acc (zero-extended, unsigned) and increments cnt.
  - the beat where cnt+1==eff_len completes the vector with sum=acc+in_product, then returns to IDLE with acc=0, cnt=0.
  - cycles without in_valid leave all state unchanged; gaps are allowed anywhere.
- Completion: sum is pushed to the FIFO on that edge; out_valid rises the following cycle. Latency from the last beat to out_valid is 1 cycle.
- Back-to-back vectors: a new vector's first beat may arrive the cycle after completion with no bubble.
- Flush:
  - synchronous; returns the FSM to IDLE and clears acc and cnt.
  - a beat arriving in the same cycle as flush is discarded, even if it would complete the vector.
  - FIFO contents are untouched.
  - flush while IDLE has no effect.
- Output handshake:
  - pop when out_valid && out_ready.
  - out_sum holds stable while out_valid=1 and out_ready=0.
  - out_sum is don't-care when out_valid=0, but the bench checks it is 0 after reset.
- FIFO full:
  - push and pop in the same cycle both succeed.
  - push when full with no pop drops the new result and sets drop_err. The FIFO keeps its oldest entries.
- err_clr: clears drop_err. If err_clr coincides with a new drop, drop_err ends up set.
- Pointers: wrap modulo OBUF_DEPTH, with an extra wrap bit to distinguish full from empty.
- No overflow is possible: ACC_W is sized for the worst case.

Decomposition:
- Shared package vecmac_pkg holds:
  - MAX_LEN, LEN_W, ACC_W, PROD_W=16 constants.
  - state enum {IDLE, ACCUM}.
  - clamp-length function.
- One natural sub-module: vecmac_sync_fifo (parameterised width/depth synchronous FIFO with push, pop, full, empty), reusable by the other result paths.
- The FSM and accumulator stay in the top module.

Test Plan:
- Basic: cfg_len=4, four back-to-back beats of 65025 -> one out_valid pulse with out_sum=260100, arriving 1 cycle after the 4th beat; out_ready=1 throughout.
- Worst case plus clamp: cfg_len=0, 16 beats of 65025 -> out_sum=1040400; then cfg_len=1, beats 7 and 9 -> two results, 7 then 9, on consecutive cycles.
- Gaps and flush:
  - cfg_len=3, beats 10, (idle 2 cycles), 20, 30 -> out_sum=60.
  - next vector: beats 5 and 6, then flush together with beat 100 -> no result, busy=0.
  - then beats 1, 2, 3 -> out_sum=6.
- Backpressure/drop: out_ready=0, cfg_len=1, beats 1, 2, 3 -> FIFO holds 1, 2 and drop_err=1. Raising out_ready then yields 1 then 2 only. err_clr -> drop_err=0.
- Simultaneous push/pop when full: FIFO holds 1, 2; out_ready=1 in the same cycle as beat 3 completes -> 1 pops, 3 is stored, drop_err stays 0; the drained order is 1, 2, 3.
- Reset mid-operation: assert rst after 2 of 4 beats with one result pending -> out_valid=0 and busy=0 immediately (asynchronous). After release, a fresh 4-beat vector of 1s gives out_sum=4.
- Random reference: 1000 random 16-bit products with random cfg_len and random out_ready, checked against a scoreboard sum. drop_err must stay 0 whenever out_ready duty is at least 50% and vectors are at least 2 long.
